// File: rtl/front_panel_sequencer_pkg.sv
// Shared types and widths for the front-panel boot sequencer.
package front_panel_sequencer_pkg;

  localparam int WORD_W  = 12;  // PDP8 word / switch register width
  localparam int COUNT_W = 13;  // word counter, wide enough to hold 4096
  localparam int PHASE_W = 8;   // button phase counter

  // Top-level boot sequence states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LDPC0     = 3'd1,
    ST_WAIT_WORD = 3'd2,
    ST_DEPOSIT   = 3'd3,
    ST_LDPC_RUN  = 3'd4,
    ST_RUN_WAIT  = 3'd5,
    ST_HALT_WAIT = 3'd6,
    ST_DONE      = 3'd7
  } fp_seq_state_t;

  // Phases of a single front-panel button operation.
  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_SETUP   = 2'd1,
    PH_PRESS   = 2'd2,
    PH_RELEASE = 2'd3
  } fp_btn_phase_t;

endpackage

// File: rtl/front_panel_sequencer_pulser.sv
// Drives one front-panel button operation: presents the operand on the
// switches, then holds SETUP, PRESS and RELEASE for HOLD_CYCLES each.
// The operand stays on sw_val until the next go, so the switches are
// stable across all three phases and afterwards.
module fp_button_pulser
  import front_panel_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES = 10  // legal 1..255
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              go,
  input  logic [WORD_W-1:0] operand,
  output logic [WORD_W-1:0] sw_val,
  output logic              btn,
  output logic              done_pulse
);

  localparam logic [PHASE_W-1:0] HOLD_LAST = PHASE_W'(HOLD_CYCLES - 1);

  fp_btn_phase_t      phase;
  logic [PHASE_W-1:0] cnt;

  // Phase sequencer; btn is registered so the panel never sees a glitch.
  // NOTE: every sequential assignment is non-blocking so all flops update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge resetN) begin
    if (resetN) begin
      // NOTE: reset is asynchronous, so outputs drop immediately, even
      // in the middle of a press.
      phase  <= PH_IDLE;
      cnt    <= '0;
      sw_val <= '0;
      btn    <= 1'b0;
    end else if (go) begin
      phase  <= PH_SETUP;
      cnt    <= HOLD_LAST;
      sw_val <= operand;
      btn    <= 1'b0;
    end else if (phase != PH_IDLE) begin
      if (cnt != '0) begin
        cnt <= cnt - PHASE_W'(1);
      end else begin
        cnt <= HOLD_LAST;
        unique case (phase)
          PH_SETUP: begin
            phase <= PH_PRESS;
            btn   <= 1'b1;
          end
          PH_PRESS: begin
            phase <= PH_RELEASE;
            btn   <= 1'b0;
          end
          default: begin
            phase <= PH_IDLE;
            btn   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Last cycle of RELEASE: lets the caller chain the next operation
  // on the very edge this one ends.
  assign done_pulse = (phase == PH_RELEASE) && (cnt == '0);

endmodule

// File: rtl/front_panel_sequencer.sv
// Boots a PDP8 through its front panel: load PC, deposit an image stream,
// load the start PC, raise the run switch and wait for run then halt.
module front_panel_sequencer
  import front_panel_sequencer_pkg::*;
#(
  parameter int                HOLD_CYCLES = 10,
  parameter logic [WORD_W-1:0] LOAD_PC     = 12'o0000,
  parameter logic [WORD_W-1:0] START_PC    = 12'o0200,
  parameter int                MAX_WORDS   = 4096
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               start,
  input  logic               img_valid,
  input  logic [WORD_W-1:0]  img_data,
  input  logic               img_last,
  output logic               img_ready,
  input  logic               run_led,
  output logic [WORD_W:0]    sw,
  output logic               load_pc_btn,
  output logic               deposit_btn,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [COUNT_W-1:0] words_loaded
);

  localparam logic [PHASE_W-1:0] HOLD_LAST = PHASE_W'(HOLD_CYCLES - 1);
  localparam logic [COUNT_W-1:0] MAX_W     = COUNT_W'(MAX_WORDS);

  fp_seq_state_t      state;
  logic               last_q;      // latched img_last of the word being deposited
  logic               sw_run;      // run switch
  logic               sw_zero;     // blank the switch register after an abort
  logic               gap_active;  // waiting between LDPC_RUN release and run switch
  logic [PHASE_W-1:0] gap_cnt;
  logic               run_meta;
  logic               run_sync;

  logic               go;
  logic [WORD_W-1:0]  operand;
  logic [WORD_W-1:0]  sw_val;
  logic               btn;
  logic               pulse_done;

  logic               start_ok;
  logic               xfer;
  logic               word_done;
  logic [COUNT_W-1:0] words_next;

  assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign img_ready  = (state == ST_WAIT_WORD);
  assign xfer       = img_ready && img_valid;
  assign word_done  = (state == ST_DEPOSIT) && pulse_done;
  assign words_next = words_loaded + COUNT_W'(1);

  // Launch a button operation on the same edge that enters its state, so
  // the SETUP phase begins the cycle right after the triggering edge.
  always_comb begin
    // NOTE: defaults first so no path leaves go/operand unassigned,
    // which would otherwise infer latches.
    go      = 1'b0;
    operand = LOAD_PC;
    if (start_ok) begin
      go      = 1'b1;
      operand = LOAD_PC;
    end else if (xfer) begin
      go      = 1'b1;
      operand = img_data;
    end else if (word_done && last_q) begin
      go      = 1'b1;
      operand = START_PC;
    end
  end

  fp_button_pulser #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_pulser (
    .clock      (clock),
    .resetN     (resetN),
    .go         (go),
    .operand    (operand),
    .sw_val     (sw_val),
    .btn        (btn),
    .done_pulse (pulse_done)
  );

  // The shared button goes to whichever panel input the current state owns;
  // state never changes while btn is high.
  assign load_pc_btn = btn && ((state == ST_LDPC0) || (state == ST_LDPC_RUN));
  assign deposit_btn = btn && (state == ST_DEPOSIT);
  assign sw          = {sw_run, sw_zero ? '0 : sw_val};

  // Two-flop synchroniser for the CPU run indicator.
  always_ff @(posedge clock or posedge resetN) begin
    if (resetN) begin
      run_meta <= 1'b0;
      run_sync <= 1'b0;
    end else begin
      run_meta <= run_led;
      run_sync <= run_meta;
    end
  end

  // Boot sequence FSM with registered status outputs.
  always_ff @(posedge clock or posedge resetN) begin
    if (resetN) begin
      state        <= ST_IDLE;
      last_q       <= 1'b0;
      sw_run       <= 1'b0;
      sw_zero      <= 1'b0;
      gap_active   <= 1'b0;
      gap_cnt      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state        <= ST_LDPC0;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            sw_zero      <= 1'b0;
          end
        end
        ST_LDPC0: begin
          if (pulse_done) state <= ST_WAIT_WORD;
        end
        ST_WAIT_WORD: begin
          if (img_valid) begin
            last_q <= img_last;
            state  <= ST_DEPOSIT;
          end
        end
        ST_DEPOSIT: begin
          if (pulse_done) begin
            words_loaded <= words_next;
            if (last_q) begin
              state <= ST_LDPC_RUN;
            end else if (words_next == MAX_W) begin
              err     <= 1'b1;
              done    <= 1'b1;
              busy    <= 1'b0;
              sw_zero <= 1'b1;
              state   <= ST_DONE;
            end else begin
              state <= ST_WAIT_WORD;
            end
          end
        end
        ST_LDPC_RUN: begin
          if (gap_active) begin
            if (gap_cnt == '0) begin
              gap_active <= 1'b0;
              sw_run     <= 1'b1;
              state      <= ST_RUN_WAIT;
            end else begin
              gap_cnt <= gap_cnt - PHASE_W'(1);
            end
          end else if (pulse_done) begin
            gap_active <= 1'b1;
            gap_cnt    <= HOLD_LAST;
          end
        end
        ST_RUN_WAIT: begin
          if (run_sync) state <= ST_HALT_WAIT;
        end
        ST_HALT_WAIT: begin
          if (!run_sync) begin
            sw_run <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_front_panel_sequencer.sv
// Bench for front_panel_sequencer: random boot images against a
// transaction-level model of the expected button operations.
module tb_front_panel_sequencer;

  localparam int          HOLD = 10;
  localparam int          MAXW = 4;
  localparam logic [11:0] LPC  = 12'o0000;
  localparam logic [11:0] SPC  = 12'o0200;

  logic        clock     = 1'b0;
  logic        resetN    = 1'b1;
  logic        start     = 1'b0;
  logic        img_valid = 1'b0;
  logic [11:0] img_data  = '0;
  logic        img_last  = 1'b0;
  logic        run_led   = 1'b0;
  logic        img_ready;
  logic [12:0] sw;
  logic        load_pc_btn;
  logic        deposit_btn;
  logic        busy;
  logic        done;
  logic        err;
  logic [12:0] words_loaded;

  int total = 0;
  int bad   = 0;

  logic [11:0] img_words [16];

  always #5 clock = ~clock;

  front_panel_sequencer #(
    .HOLD_CYCLES (HOLD),
    .LOAD_PC     (LPC),
    .START_PC    (SPC),
    .MAX_WORDS   (MAXW)
  ) dut (
    .clock        (clock),
    .resetN       (resetN),
    .start        (start),
    .img_valid    (img_valid),
    .img_data     (img_data),
    .img_last     (img_last),
    .img_ready    (img_ready),
    .run_led      (run_led),
    .sw           (sw),
    .load_pc_btn  (load_pc_btn),
    .deposit_btn  (deposit_btn),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Button press observer: one record per completed press.
  typedef struct packed {
    logic        dep;
    logic [11:0] swv;
    logic [15:0] len;
    logic        moved;
  } ev_t;

  ev_t         obs_q [$];
  int          both_high   = 0;
  int          sw12_cycles = 0;
  logic [15:0] cur_len     = '0;
  logic        cur_dep     = 1'b0;
  logic [11:0] cur_sw      = '0;
  logic        cur_moved   = 1'b0;

  always @(negedge clock) begin
    if (resetN) begin
      cur_len <= '0;
    end else begin
      if (load_pc_btn && deposit_btn) both_high <= both_high + 1;
      if (sw[12]) sw12_cycles <= sw12_cycles + 1;
      if (cur_len == 0) begin
        if (load_pc_btn || deposit_btn) begin
          cur_dep   <= deposit_btn;
          cur_sw    <= sw[11:0];
          cur_len   <= 16'd1;
          cur_moved <= 1'b0;
        end
      end else if (cur_dep ? deposit_btn : load_pc_btn) begin
        cur_len <= cur_len + 16'd1;
        if (sw[11:0] != cur_sw) cur_moved <= 1'b1;
      end else begin
        obs_q.push_back(ev_t'{dep: cur_dep, swv: cur_sw, len: cur_len, moved: cur_moved});
        cur_len <= '0;
      end
    end
  end

  // Assert reset mid-cycle and confirm every output drops at once.
  task automatic reset_check(input string tag);
    @(posedge clock);
    #3 resetN = 1'b1;
    #1;
    check({tag, "_sw"},    32'(sw), 0);
    check({tag, "_btns"},  32'({load_pc_btn, deposit_btn}), 0);
    check({tag, "_flags"}, 32'({busy, done, err, img_ready}), 0);
    check({tag, "_words"}, 32'(words_loaded), 0);
    img_valid = 1'b0;
    run_led   = 1'b0;
    start     = 1'b0;
    repeat (2) @(negedge clock);
    resetN = 1'b0;
  endtask

  // Pulse start and check the LDPC0 timing up to WAIT_WORD entry.
  task automatic start_seq();
    int first_btn = -1;
    int first_rdy = -1;
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int c = 0; c < 8 * HOLD; c++) begin
      @(negedge clock);
      if (c == 0) begin
        check("start_busy",  32'(busy), 1);
        check("start_done",  32'({done, err}), 0);
        check("start_words", 32'(words_loaded), 0);
        check("start_sw",    32'(sw), 32'({1'b0, LPC}));
      end
      if (load_pc_btn && first_btn < 0) first_btn = c;
      if (img_ready) begin
        first_rdy = c;
        break;
      end
    end
    check("ldpc0_press_cycle", 32'(first_btn), 32'(HOLD));
    check("wait_word_cycle",   32'(first_rdy), 32'(3 * HOLD));
  endtask

  // Offer one word, optionally stalling first; ok=0 if the sequence ended.
  task automatic feed_one(input logic [11:0] d, input logic l, input int stall, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (img_ready || done) break;
    end
    if (done) return;
    if (!img_ready) begin
      check("img_ready_timeout", 0, 1);
      return;
    end
    if (stall > 0) begin
      int noisy = 0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clock);
        if (!img_ready || load_pc_btn || deposit_btn) noisy++;
      end
      check("stall_quiet", 32'(noisy), 0);
    end
    img_data  = d;
    img_last  = l;
    img_valid = 1'b1;
    @(posedge clock);
    #1;
    img_valid = 1'b0;
    img_last  = 1'b0;
    ok = 1'b1;
  endtask

  // One full boot of img_words[0..n-1], checked against the expected
  // list of panel operations and the final status.
  task automatic run_boot(input int n, input bit has_last, input int stall_at,
                          input int stall_len, input bit poke_start);
    int  base    = obs_q.size();
    int  s12     = sw12_cycles;
    int  bh      = both_high;
    int  dep     = 0;
    bit  ovf     = 1'b0;
    int  n_ev;
    bit  ok;
    int  fall_c  = -1;
    int  rise_c  = -1;
    bit  was_hi  = 1'b0;
    ev_t e;

    // Expected deposits: stop at the last word, or abort at MAXW words.
    for (int i = 0; i < n; i++) begin
      dep++;
      if (has_last && i == n - 1) break;
      if (dep == MAXW) begin
        ovf = 1'b1;
        break;
      end
    end

    start_seq();
    for (int i = 0; i < n; i++) begin
      feed_one(img_words[i], has_last && (i == n - 1), (i == stall_at) ? stall_len : 0, ok);
      if (!ok) break;
      if (poke_start && i == 0) begin
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        check("poke_busy",  32'(busy), 1);
        check("poke_words", 32'(words_loaded), 0);
        check("poke_ldpc",  32'(load_pc_btn), 0);
      end
    end

    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      if (was_hi && !load_pc_btn && fall_c < 0) fall_c = c;
      was_hi = load_pc_btn;
      if (sw[12]) begin
        rise_c = c;
        break;
      end
      if (done) break;
    end
    if (!ovf) check("run_sw_gap", 32'(rise_c - fall_c), 32'(2 * HOLD));
    if (sw[12]) begin
      repeat ($urandom_range(0, 4)) @(negedge clock);
      run_led = 1'b1;
      repeat ($urandom_range(3, 8)) @(negedge clock);
      check("done_before_halt", 32'(done), 0);
      run_led = 1'b0;
    end
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (done) break;
    end

    n_ev = dep + (ovf ? 1 : 2);
    check("event_count", 32'(obs_q.size() - base), 32'(n_ev));
    for (int k = 0; k < n_ev && base + k < obs_q.size(); k++) begin
      logic        exp_dep;
      logic [11:0] exp_sw;
      e       = obs_q[base + k];
      exp_dep = (k >= 1 && k <= dep);
      exp_sw  = (k == 0) ? LPC : (k <= dep) ? img_words[k - 1] : SPC;
      check($sformatf("ev%0d_kind", k),  32'(e.dep),   32'(exp_dep));
      check($sformatf("ev%0d_sw", k),    32'(e.swv),   32'(exp_sw));
      check($sformatf("ev%0d_len", k),   32'(e.len),   32'(HOLD));
      check($sformatf("ev%0d_moved", k), 32'(e.moved), 0);
    end
    check("run_sw_seen", 32'((sw12_cycles - s12) > 0), 32'(!ovf));
    check("both_btns",   32'(both_high - bh), 0);
    check("end_done",    32'({busy, done}), 32'(2'b01));
    check("end_err",     32'(err), 32'(ovf));
    check("end_words",   32'(words_loaded), 32'(dep));
    check("end_sw",      32'(sw), 32'({1'b0, ovf ? 12'o0000 : SPC}));
    check("end_ready",   32'(img_ready), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;

    // Reset state.
    repeat (3) @(negedge clock);
    check("reset_outputs", 32'({sw, load_pc_btn, deposit_btn, busy, done, err, img_ready}), 0);
    check("reset_words",   32'(words_loaded), 0);
    resetN = 1'b0;

    // Directed three-word boot.
    img_words[0] = 12'o7402;
    img_words[1] = 12'o1234;
    img_words[2] = 12'o0002;
    run_boot(3, 1'b1, -1, 0, 1'b0);

    // Source stall of 50 cycles before the second word.
    for (int i = 0; i < 3; i++) img_words[i] = 12'($urandom);
    run_boot(3, 1'b1, 1, 50, 1'b0);

    // Start pulsed while busy.
    for (int i = 0; i < 3; i++) img_words[i] = 12'($urandom);
    run_boot(3, 1'b1, -1, 0, 1'b1);

    // Overflow: five words, none marked last.
    for (int i = 0; i < 5; i++) img_words[i] = 12'($urandom);
    run_boot(5, 1'b0, -1, 0, 1'b0);

    // Reset during the LDPC0 press.
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int c = 0; c < 4 * HOLD; c++) begin
      @(negedge clock);
      if (load_pc_btn) break;
    end
    check("t1_in_press", 32'(load_pc_btn), 1);
    reset_check("t1_reset");

    // Reset during the second deposit press, then a fresh boot.
    img_words[0] = 12'($urandom);
    img_words[1] = 12'($urandom);
    start_seq();
    feed_one(img_words[0], 1'b0, 0, ok);
    feed_one(img_words[1], 1'b0, 0, ok);
    for (int c = 0; c < 4 * HOLD; c++) begin
      @(negedge clock);
      if (deposit_btn) break;
    end
    check("t6_in_press", 32'(deposit_btn), 1);
    check("t6_words",    32'(words_loaded), 1);
    reset_check("t6_reset");
    for (int i = 0; i < 2; i++) img_words[i] = 12'($urandom);
    run_boot(2, 1'b1, -1, 0, 1'b0);

    // Random images.
    for (int t = 0; t < 6; t++) begin
      int n        = $urandom_range(1, MAXW + 1);
      bit has_last = ($urandom_range(0, 3) != 0);
      if (!has_last) n = MAXW + $urandom_range(0, 1);
      for (int i = 0; i < n; i++) img_words[i] = 12'($urandom);
      run_boot(n, has_last, $urandom_range(0, n - 1), $urandom_range(0, 5),
               1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
